// File: rtl/mux_pkg.sv
// Shared constants and elaboration helpers for the pipelined mux tree.
package mux_pkg;

    localparam int N_CH_DEF = 8;
    localparam int DW_DEF   = 8;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux2_reg.sv
// Registered 2:1 mux cell: loads the selected input only on a valid beat,
// otherwise holds so the data path does not toggle on bubbles.
module mux2_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          sel,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y
);

    logic [DW-1:0] y_d;
    logic [DW-1:0] y_q;

    always_comb begin
        y_d = y_q;
        if (in_valid) begin
            y_d = sel ? b : a;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N_CH:1 mux built as a binary tree of registered 2:1 cells, one
// register bank per tree level, with an optional round-robin scan select.
module mux_tree_pipe
    import mux_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int DW   = DW_DEF,
    localparam int SW  = clog2(N_CH),
    localparam int LAT = SW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CH*DW-1:0] d,
    input  logic [SW-1:0]      s,
    input  logic               in_valid,
    input  logic               scan_en,
    output logic [DW-1:0]      y,
    output logic [SW-1:0]      y_sel,
    output logic               out_valid
);

    logic [SW-1:0]           scan_cnt_d;
    logic [SW-1:0]           scan_cnt_q;
    logic [SW-1:0]           sel_eff;

    logic [LAT-1:0]          lvl_vld_in;
    logic [LAT-1:0]          lvl_vld_q;
    logic [LAT-1:0][SW-1:0]  lvl_sel_in;
    logic [LAT-1:0][SW-1:0]  lvl_sel_d;
    logic [LAT-1:0][SW-1:0]  lvl_sel_q;

    // Heap-ordered tree: node 0 is the root, node i has children 2i+1 / 2i+2,
    // and channel c sits at leaf N_CH-1+c so lower channels are left children.
    logic [2*N_CH-2:0][DW-1:0] node;

    // Scan counter wraps naturally because N_CH is a power of two.
    always_comb begin
        sel_eff    = scan_en ? scan_cnt_q : s;
        scan_cnt_d = scan_cnt_q;
        if (!scan_en) begin
            scan_cnt_d = '0;
        end else if (in_valid) begin
            scan_cnt_d = scan_cnt_q + SW'(1);
        end
    end

    // Level k consumes the beat registered by level k-1; level 0 takes the input.
    always_comb begin
        lvl_vld_in    = '0;
        lvl_sel_in    = '0;
        lvl_vld_in[0] = in_valid;
        lvl_sel_in[0] = sel_eff;
        for (int k = 1; k < LAT; k++) begin
            lvl_vld_in[k] = lvl_vld_q[k-1];
            lvl_sel_in[k] = lvl_sel_q[k-1];
        end
        for (int k = 0; k < LAT; k++) begin
            lvl_sel_d[k] = lvl_vld_in[k] ? lvl_sel_in[k] : lvl_sel_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            lvl_vld_q  <= '0;
            lvl_sel_q  <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            lvl_vld_q  <= lvl_vld_in;
            lvl_sel_q  <= lvl_sel_d;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_leaf
        assign node[N_CH-1+c] = d[c*DW +: DW];
    end

    // A node at depth dd resolves select bit SW-1-dd, i.e. level SW-1-dd.
    for (genvar i = 0; i < N_CH-1; i++) begin : g_cell
        localparam int LV = SW - clog2(i + 2);

        mux2_reg #(
            .DW (DW)
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (lvl_vld_in[LV]),
            .sel      (lvl_sel_in[LV][LV]),
            .a        (node[2*i+1]),
            .b        (node[2*i+2]),
            .y        (node[i])
        );
    end

    assign y         = node[0];
    assign y_sel     = lvl_sel_q[LAT-1];
    assign out_valid = lvl_vld_q[LAT-1];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: three configurations (8x8, 2x8, 64x1) driven in
// lockstep, checked every cycle against a history-based model plus literals.
module tb_mux_tree_pipe;

    localparam int MAXE = 2048;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        scan_en;

    logic [63:0] d_a;
    logic [2:0]  s_a;
    logic [7:0]  y_a;
    logic [2:0]  ysel_a;
    logic        ov_a;

    logic [15:0] d_b;
    logic        s_b;
    logic [7:0]  y_b;
    logic        ysel_b;
    logic        ov_b;

    logic [63:0] d_c;
    logic [5:0]  s_c;
    logic        y_c;
    logic [5:0]  ysel_c;
    logic        ov_c;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux_tree_pipe #(.N_CH(8), .DW(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .d(d_a), .s(s_a), .in_valid(in_valid),
        .scan_en(scan_en), .y(y_a), .y_sel(ysel_a), .out_valid(ov_a)
    );

    mux_tree_pipe #(.N_CH(2), .DW(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .d(d_b), .s(s_b), .in_valid(in_valid),
        .scan_en(scan_en), .y(y_b), .y_sel(ysel_b), .out_valid(ov_b)
    );

    mux_tree_pipe #(.N_CH(64), .DW(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .d(d_c), .s(s_c), .in_valid(in_valid),
        .scan_en(scan_en), .y(y_c), .y_sel(ysel_c), .out_valid(ov_c)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: per edge, record what each instance accepted. The output after
    // edge n is the newest beat accepted in (last reset, n-LAT+1], else zero.
    int          lat_of [0:2] = '{3, 1, 6};
    int          nch_of [0:2] = '{8, 2, 64};
    bit          acc    [0:2][0:MAXE-1];
    int          hsel   [0:2][0:MAXE-1];
    logic [7:0]  hdat   [0:2][0:MAXE-1];
    int          cnt    [0:2] = '{0, 0, 0};
    int          last_rst = -1;
    int          ne = 0;
    int          rsel;
    logic [7:0]  rdat;

    always @(posedge clk) begin
        if (ne < MAXE) begin
            if (!rst_n) last_rst = ne;
            for (int i = 0; i < 3; i++) begin
                case (i)
                    0:       rsel = scan_en ? cnt[i] : int'(s_a);
                    1:       rsel = scan_en ? cnt[i] : int'(s_b);
                    default: rsel = scan_en ? cnt[i] : int'(s_c);
                endcase
                case (i)
                    0:       rdat = d_a[rsel*8 +: 8];
                    1:       rdat = d_b[rsel*8 +: 8];
                    default: rdat = {7'b0, d_c[rsel]};
                endcase
                acc[i][ne]  = rst_n && in_valid;
                hsel[i][ne] = rsel;
                hdat[i][ne] = rdat;
                if (!rst_n || !scan_en) cnt[i] = 0;
                else if (in_valid)      cnt[i] = (cnt[i] + 1) % nch_of[i];
            end
        end
        ne = ne + 1;
    end

    int         cn;
    int         cm0;
    bit         ev;
    logic [7:0] ey;
    int         es;
    logic       av;
    logic [7:0] ay;
    int         as_;

    always @(negedge clk) begin
        if (ne > 0 && ne <= MAXE && last_rst >= 0) begin
            cn = ne - 1;
            for (int i = 0; i < 3; i++) begin
                cm0 = cn - lat_of[i] + 1;
                ev = 1'b0;
                ey = '0;
                es = 0;
                if (cm0 > last_rst) begin
                    ev = acc[i][cm0];
                    for (int m = cm0; m > last_rst; m--) begin
                        if (acc[i][m]) begin
                            ey = hdat[i][m];
                            es = hsel[i][m];
                            break;
                        end
                    end
                end
                case (i)
                    0:       begin av = ov_a; ay = y_a;          as_ = int'(ysel_a); end
                    1:       begin av = ov_b; ay = y_b;          as_ = int'(ysel_b); end
                    default: begin av = ov_c; ay = {7'b0, y_c};  as_ = int'(ysel_c); end
                endcase
                chk($sformatf("model[%0d] out_valid", i), 64'(av), 64'(ev));
                chk($sformatf("model[%0d] y", i), 64'(ay), 64'(ey));
                chk($sformatf("model[%0d] y_sel", i), 64'(as_), 64'(es));
            end
        end
    end

    // Present one cycle of inputs, then return at the following falling edge
    // where outputs reflect the rising edge that consumed them.
    task automatic drive(input logic rn, input logic v, input logic se, input logic [2:0] sa);
        rst_n    = rn;
        in_valid = v;
        scan_en  = se;
        s_a      = sa;
        s_b      = sa[0];
        s_c      = 6'($urandom);
        d_b      = 16'($urandom);
        d_c      = {$urandom, $urandom};
        @(negedge clk);
    endtask

    int exp36 [0:4] = '{0, 1, 2, 6, 0};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; scan_en = 1'b0;
        s_a = '0; s_b = 1'b0; s_c = '0; d_b = '0; d_c = '0;
        for (int i = 0; i < 8; i++) d_a[i*8 +: 8] = 8'(8'h11 * i);

        drive(0, 1, 0, 3'd5);
        drive(0, 1, 0, 3'd5);
        chk("rst ov", 64'(ov_a), 64'd0);
        chk("rst y", 64'(y_a), 64'd0);
        chk("rst ysel", 64'(ysel_a), 64'd0);

        // Fixed select sweep 0..7
        for (int k = 0; k < 8; k++) begin
            drive(1, 1, 0, 3'(k));
            if (k < 2) begin
                chk("sweep ov early", 64'(ov_a), 64'd0);
            end else begin
                chk("sweep ov", 64'(ov_a), 64'd1);
                chk("sweep y", 64'(y_a), 64'(8'h11 * (k - 2)));
                chk("sweep ysel", 64'(ysel_a), 64'(k - 2));
            end
        end
        drive(1, 0, 0, 3'd0);
        chk("sweep tail y6", 64'(y_a), 64'h66);
        drive(1, 0, 0, 3'd0);
        chk("sweep tail y7", 64'(y_a), 64'h77);
        drive(1, 0, 0, 3'd0);
        chk("sweep drained ov", 64'(ov_a), 64'd0);
        chk("sweep held y", 64'(y_a), 64'h77);

        // Round-robin scan for 10 beats
        for (int j = 0; j < 10; j++) begin
            drive(1, 1, 1, 3'd0);
            if (j >= 2) begin
                chk("scan ysel", 64'(ysel_a), 64'((j - 2) % 8));
                chk("scan y", 64'(y_a), 64'(8'h11 * ((j - 2) % 8)));
            end
        end
        drive(1, 0, 0, 3'd0);
        chk("scan wrap ysel0", 64'(ysel_a), 64'd0);
        chk("scan wrap y00", 64'(y_a), 64'h00);
        drive(1, 0, 0, 3'd0);
        chk("scan wrap ysel1", 64'(ysel_a), 64'd1);
        chk("scan wrap y11", 64'(y_a), 64'h11);

        // Bubble between two beats
        drive(1, 1, 0, 3'd5);
        drive(1, 0, 0, 3'd0);
        drive(1, 1, 0, 3'd2);
        chk("bubble ov1", 64'(ov_a), 64'd1);
        chk("bubble y55", 64'(y_a), 64'h55);
        drive(1, 0, 0, 3'd0);
        chk("bubble ov0", 64'(ov_a), 64'd0);
        chk("bubble y held", 64'(y_a), 64'h55);
        drive(1, 0, 0, 3'd0);
        chk("bubble ov2", 64'(ov_a), 64'd1);
        chk("bubble y22", 64'(y_a), 64'h22);

        // Scan / fixed interleave
        drive(1, 1, 1, 3'd0);
        drive(1, 1, 1, 3'd0);
        drive(1, 1, 1, 3'd0);
        chk("mix ysel0", 64'(ysel_a), 64'(exp36[0]));
        drive(1, 1, 0, 3'd6);
        chk("mix ysel1", 64'(ysel_a), 64'(exp36[1]));
        drive(1, 1, 1, 3'd0);
        chk("mix ysel2", 64'(ysel_a), 64'(exp36[2]));
        drive(1, 0, 0, 3'd0);
        chk("mix ysel6", 64'(ysel_a), 64'(exp36[3]));
        chk("mix y66", 64'(y_a), 64'h66);
        drive(1, 0, 0, 3'd0);
        chk("mix ysel restart", 64'(ysel_a), 64'(exp36[4]));

        // Scan counter holds across an idle cycle
        drive(1, 1, 1, 3'd0);
        drive(1, 0, 1, 3'd0);
        drive(1, 1, 1, 3'd0);
        chk("hold ysel0", 64'(ysel_a), 64'd0);
        drive(1, 0, 0, 3'd0);
        chk("hold ov bubble", 64'(ov_a), 64'd0);
        drive(1, 0, 0, 3'd0);
        chk("hold ysel1", 64'(ysel_a), 64'd1);
        chk("hold y11", 64'(y_a), 64'h11);

        // Reset with three beats in flight
        drive(1, 1, 0, 3'd1);
        drive(1, 1, 0, 3'd2);
        drive(1, 1, 0, 3'd3);
        drive(0, 1, 0, 3'd4);
        chk("flush ov", 64'(ov_a), 64'd0);
        chk("flush y", 64'(y_a), 64'd0);
        chk("flush ysel", 64'(ysel_a), 64'd0);
        for (int j = 0; j < 4; j++) begin
            drive(1, 0, 0, 3'd0);
            chk("flush no stale ov", 64'(ov_a), 64'd0);
            chk("flush no stale y", 64'(y_a), 64'd0);
        end

        // Random traffic across all three configurations
        for (int j = 0; j < 250; j++) begin
            d_a = {$urandom, $urandom};
            drive(logic'($urandom_range(0, 49) != 0), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 2) != 0), 3'($urandom));
        end
        drive(1, 0, 0, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
